// File: rtl/demux_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_router_pkg
// Description : Shared types, default widths and stimulus bounds for the
//               demux_router block and its holding-slot sub-module.
//               Provides the slot state encoding and a channel-free helper.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_router_pkg;

  // Default width of the routed data word.
  localparam int c_data_width        = 32;
  // Default width of the per-channel delivered-word counters.
  localparam int c_cnt_width         = 8;

  // Random-traffic length and word value range used by the block's bench.
  localparam int c_num_demux_test    = 200;
  localparam int c_demux_lower_bound = 1;
  localparam int c_demux_upper_bound = 250;

  // One-entry holding slot: EMPTY (no word) or FULL (valid word held).
  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // A channel can take a new word when it is empty, or when the word it
  // holds leaves this very cycle.
  function automatic logic chan_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One-entry holding register for a single destination channel
//               of demux_router, with EMPTY/FULL valid state and a wrapping
//               delivered-word counter.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               flush             - synchronous drop of the held word
//               load, load_data   - write a new word into the slot
//               data, valid       - held word and its valid flag (registered)
//               ready             - downstream sink accepts the held word
//               free              - slot can take a load this cycle
//               count             - number of words delivered (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
  import demux_router_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width,
  parameter int CNT_WIDTH  = c_cnt_width
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  free,
  output logic [CNT_WIDTH-1:0]  count
);

  slot_state_t           r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  w_deliver;

  assign w_deliver = (r_state == SLOT_FULL) && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      // A handshake counts even in a flush cycle: the sink already took it.
      if (w_deliver) begin
        r_count <= r_count + 1'b1;
      end

      case (r_state)
        SLOT_EMPTY: begin
          if (!flush && load) begin
            r_data  <= load_data;
            r_state <= SLOT_FULL;
          end
        end
        SLOT_FULL: begin
          if (flush) begin
            // Held word dropped; data register keeps its last value.
            r_state <= SLOT_EMPTY;
          end else if (load) begin
            // Load only happens here when the held word leaves this cycle,
            // so the slot stays FULL with the replacement word.
            r_data <= load_data;
          end else if (ready) begin
            r_state <= SLOT_EMPTY;
          end
        end
        default: begin
          r_state <= SLOT_EMPTY;
        end
      endcase
    end
  end

  assign data  = r_data;
  assign valid = (r_state == SLOT_FULL);
  assign count = r_count;
  assign free  = chan_free(valid, ready);

endmodule
`default_nettype wire

// File: rtl/demux_router.sv
`default_nettype none
// ============================================================================
// Module      : demux_router
// Description : Routes one source word onto the True or False channel
//               selected by Cond, with valid/ready handshakes on all sides
//               and a one-entry holding slot per destination channel.
// Ports       : Clk, Reset_n                 - clock, async active-low reset
//               Flush                        - drop both held words
//               In, In_valid, Cond, In_ready - source side (In_ready comb.)
//               True, True_valid, True_ready - True channel
//               False, False_valid, False_ready - False channel
//               True_count, False_count      - delivered-word counters
// Revision    : 1.0 - initial release
// ============================================================================
module demux_router
  import demux_router_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width,
  parameter int CNT_WIDTH  = c_cnt_width
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Flush,
  input  logic [DATA_WIDTH-1:0] In,
  input  logic                  In_valid,
  input  logic                  Cond,
  output logic                  In_ready,
  output logic [DATA_WIDTH-1:0] True,
  output logic                  True_valid,
  input  logic                  True_ready,
  output logic [DATA_WIDTH-1:0] False,
  output logic                  False_valid,
  input  logic                  False_ready,
  output logic [CNT_WIDTH-1:0]  True_count,
  output logic [CNT_WIDTH-1:0]  False_count
);

  logic w_true_free;
  logic w_false_free;
  logic w_accept;
  logic w_load_true;
  logic w_load_false;

  // Only the selected channel gates the source; a stalled channel that is
  // not selected never blocks traffic to the other one.
  assign In_ready     = !Flush && (Cond ? w_true_free : w_false_free);
  assign w_accept     = In_valid && In_ready;
  assign w_load_true  = w_accept && Cond;
  assign w_load_false = w_accept && !Cond;

  demux_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_true_slot (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .flush     (Flush),
    .load      (w_load_true),
    .load_data (In),
    .data      (True),
    .valid     (True_valid),
    .ready     (True_ready),
    .free      (w_true_free),
    .count     (True_count)
  );

  demux_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_false_slot (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .flush     (Flush),
    .load      (w_load_false),
    .load_data (In),
    .data      (False),
    .valid     (False_valid),
    .ready     (False_ready),
    .free      (w_false_free),
    .count     (False_count)
  );

endmodule
`default_nettype wire
